if_id_stage: RTL and testbench

- Instruction-fetch stage plus IF/ID pipeline register for the 8-bit CPU.
- Holds the PC, fetches 8-bit instructions from instruction memory, and presents the fetched instruction, its PC and split fields to decode.
- The 3-bit immediate field feeds the sign-extend unit downstream.
- Consumes the sign-extended 8-bit branch offset back from decode/EX to redirect the PC.

---
 rtl/cpu_pkg.sv | 19 +
 rtl/pc_unit.sv | 38 +++
 rtl/if_id_stage.sv | 141 ++++++++++++++
 tb/tb_if_id_stage.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared constants and fetch-state encoding for the 8-bit CPU front end.
package cpu_pkg;

    localparam int unsigned DATA_W     = 8;
    localparam int unsigned IMM_W      = 3;
    localparam int unsigned OPCODE_MSB = 7;
    localparam int unsigned OPCODE_LSB = 5;
    localparam int unsigned IMM_MSB    = 2;
    localparam int unsigned IMM_LSB    = 0;

    localparam logic [DATA_W-1:0] HALT_INSTR = 8'hFF;

    typedef enum logic [1:0] {
        FETCH,
        HOLD,
        HALT
    } fetch_state_e;

endpackage

// File: rtl/pc_unit.sv
// Program counter register with next-PC selection: reset value, branch target
// (id_pc + 1 + offset, wrapping) or sequential increment.
module pc_unit #(
    parameter int unsigned        DATA_W   = 8,
    parameter logic [DATA_W-1:0]  RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              advance,
    input  logic              redirect,
    input  logic [DATA_W-1:0] id_pc,
    input  logic [DATA_W-1:0] offset,
    output logic [DATA_W-1:0] pc
);

    logic [DATA_W-1:0] pc_d;
    logic [DATA_W-1:0] target;

    assign target = id_pc + DATA_W'(1) + offset;

    always_comb begin
        pc_d = pc;
        if (redirect) begin
            pc_d = target;
        end else if (advance) begin
            pc_d = pc + DATA_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc <= RESET_PC;
        end else begin
            pc <= pc_d;
        end
    end

endmodule

// File: rtl/if_id_stage.sv
// Instruction fetch plus IF/ID pipeline register with a one-entry skid buffer.
// Optional HALT_DETECT_EN: loading 8'hFF into ID parks the stage in HALT.
module if_id_stage #(
    parameter int unsigned        DATA_W   = cpu_pkg::DATA_W,
    parameter int unsigned        IMM_W    = cpu_pkg::IMM_W,
    parameter logic [DATA_W-1:0]  RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req,
    output logic [DATA_W-1:0] imem_addr,
    input  logic [DATA_W-1:0] imem_rdata,
    input  logic              imem_valid,
    input  logic              stall,
    input  logic              branch_taken,
    input  logic [DATA_W-1:0] branch_offset,
    output logic [DATA_W-1:0] pc,
    output logic              id_valid,
    output logic [DATA_W-1:0] id_instr,
    output logic [DATA_W-1:0] id_pc,
    output logic [2:0]        id_opcode,
    output logic [IMM_W-1:0]  id_imm,
    output logic              halted
);

    import cpu_pkg::*;

    fetch_state_e      state_q, state_d;
    logic [DATA_W-1:0] skid_instr, skid_pc;
    logic [DATA_W-1:0] load_instr, load_pc;
    logic              advance, load_id, bubble, fill_skid;

    pc_unit #(
        .DATA_W   (DATA_W),
        .RESET_PC (RESET_PC)
    ) u_pc_unit (
        .clk      (clk),
        .rst      (rst),
        .advance  (advance),
        .redirect (branch_taken),
        .id_pc    (id_pc),
        .offset   (branch_offset),
        .pc       (pc)
    );

    assign imem_addr = pc;
    assign id_opcode = id_instr[OPCODE_MSB:OPCODE_LSB];
    assign id_imm    = id_instr[IMM_W-1:0];

    always_comb begin
        state_d    = state_q;
        imem_req   = 1'b0;
        advance    = 1'b0;
        load_id    = 1'b0;
        bubble     = 1'b0;
        fill_skid  = 1'b0;
        load_instr = imem_rdata;
        load_pc    = pc;
        case (state_q)
            FETCH: begin
                imem_req = 1'b1;
                if (imem_valid) begin
                    advance = 1'b1;
                    if (stall) begin
                        fill_skid = 1'b1;
                        state_d   = HOLD;
                    end else begin
                        load_id = 1'b1;
                    end
                end else if (!stall) begin
                    bubble = 1'b1;
                end
            end
            HOLD: begin
                if (!stall) begin
                    load_id    = 1'b1;
                    load_instr = skid_instr;
                    load_pc    = skid_pc;
                    state_d    = FETCH;
                end
            end
            default: begin
                // HALT: no request, everything holds until a redirect
            end
        endcase
`ifdef HALT_DETECT_EN
        if (load_id && (load_instr == HALT_INSTR)) begin
            state_d = HALT;
        end
`endif
        // A redirect overrides every other action, including a pending stall
        if (branch_taken) begin
            state_d   = FETCH;
            advance   = 1'b0;
            load_id   = 1'b0;
            fill_skid = 1'b0;
            bubble    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            id_valid <= 1'b0;
            id_instr <= '0;
            id_pc    <= '0;
        end else if (branch_taken) begin
            id_valid <= 1'b0;
        end else if (load_id) begin
            id_valid <= 1'b1;
            id_instr <= load_instr;
            id_pc    <= load_pc;
        end else if (bubble) begin
            id_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            skid_instr <= '0;
            skid_pc    <= '0;
        end else if (fill_skid) begin
            skid_instr <= imem_rdata;
            skid_pc    <= pc;
        end
    end

`ifdef HALT_DETECT_EN
    assign halted = (state_q == HALT);
`else
    assign halted = 1'b0;
`endif

endmodule

// File: tb/tb_if_id_stage.sv
// Directed self-checking bench for if_id_stage (default build; HALT path when
// HALT_DETECT_EN is defined).
module tb_if_id_stage;

    logic       clk;
    logic       rst;
    logic       imem_req;
    logic [7:0] imem_addr;
    logic [7:0] imem_rdata;
    logic       imem_valid;
    logic       stall;
    logic       branch_taken;
    logic [7:0] branch_offset;
    logic [7:0] pc;
    logic       id_valid;
    logic [7:0] id_instr;
    logic [7:0] id_pc;
    logic [2:0] id_opcode;
    logic [2:0] id_imm;
    logic       halted;

    int unsigned tests = 0;
    int unsigned fails = 0;

    if_id_stage #(
        .DATA_W   (8),
        .IMM_W    (3),
        .RESET_PC (8'h00)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_rdata    (imem_rdata),
        .imem_valid    (imem_valid),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_offset (branch_offset),
        .pc            (pc),
        .id_valid      (id_valid),
        .id_instr      (id_instr),
        .id_pc         (id_pc),
        .id_opcode     (id_opcode),
        .id_imm        (id_imm),
        .halted        (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; imem_valid = 1'b0; imem_rdata = '0; stall = 1'b0;
        branch_taken = 1'b0; branch_offset = '0;
        tick; tick;
        check("rst_pc", pc, 16'h00);
        check("rst_id_valid", id_valid, 16'h0);
        check("rst_id_instr", id_instr, 16'h00);
        check("rst_id_pc", id_pc, 16'h00);
        check("rst_req", imem_req, 16'h1);
        check("rst_addr", imem_addr, 16'h00);
        check("rst_opcode", id_opcode, 16'h0);
        check("rst_imm", id_imm, 16'h0);
        check("rst_halted", halted, 16'h0);

        // Back-to-back fetches
        rst = 1'b0; imem_valid = 1'b1; imem_rdata = 8'h21;
        check("f0_addr", imem_addr, 16'h00);
        tick;
        check("f0_instr", id_instr, 16'h21);
        check("f0_id_pc", id_pc, 16'h00);
        check("f0_opcode", id_opcode, 16'h1);
        check("f0_imm", id_imm, 16'h1);
        check("f0_valid", id_valid, 16'h1);
        check("f1_addr", imem_addr, 16'h01);
        imem_rdata = 8'h43;
        tick;
        check("f1_instr", id_instr, 16'h43);
        check("f1_id_pc", id_pc, 16'h01);
        check("f1_opcode", id_opcode, 16'h2);
        check("f1_imm", id_imm, 16'h3);
        check("f2_addr", imem_addr, 16'h02);

        // Stall for three cycles with valid data at pc 02
        imem_rdata = 8'h65; stall = 1'b1;
        tick;
        check("st_req", imem_req, 16'h0);
        check("st_instr", id_instr, 16'h43);
        check("st_pc", pc, 16'h03);
        tick; tick;
        check("st3_req", imem_req, 16'h0);
        check("st3_instr", id_instr, 16'h43);
        check("st3_id_pc", id_pc, 16'h01);
        check("st3_pc", pc, 16'h03);
        stall = 1'b0; imem_rdata = 8'h87;
        tick;
        check("unst_instr", id_instr, 16'h65);
        check("unst_id_pc", id_pc, 16'h02);
        check("unst_valid", id_valid, 16'h1);
        check("unst_req", imem_req, 16'h1);
        check("unst_addr", imem_addr, 16'h03);
        tick;
        check("resume_instr", id_instr, 16'h87);
        check("resume_id_pc", id_pc, 16'h03);
        check("resume_pc", pc, 16'h04);

        // Bubble when nothing returns and no stall
        imem_valid = 1'b0;
        tick;
        check("bubble_valid", id_valid, 16'h0);
        check("bubble_pc", pc, 16'h04);

        // Branch backwards from id_pc 05 by -4
        imem_valid = 1'b1; imem_rdata = 8'hA1;
        tick;
        imem_rdata = 8'hA2;
        tick;
        check("pre_br_id_pc", id_pc, 16'h05);
        branch_taken = 1'b1; branch_offset = 8'hFC; imem_rdata = 8'h33;
        tick;
        check("br1_pc", pc, 16'h02);
        check("br1_valid", id_valid, 16'h0);
        check("br1_instr_kept", id_instr, 16'hA2);

        // Redirect to FE, fetch there, then branch forward through the wrap
        imem_valid = 1'b0; branch_offset = 8'hF8;
        tick;
        check("br2_pc", pc, 16'hFE);
        branch_taken = 1'b0; imem_valid = 1'b1; imem_rdata = 8'h11;
        tick;
        check("fe_id_pc", id_pc, 16'hFE);
        check("fe_pc", pc, 16'hFF);
        branch_taken = 1'b1; branch_offset = 8'h03; imem_valid = 1'b0;
        tick;
        check("br_wrap_pc", pc, 16'h02);
        check("br_wrap_valid", id_valid, 16'h0);

        // Sequential wrap FF -> 00
        branch_offset = 8'h00;
        tick;
        check("br_ff_pc", pc, 16'hFF);
        branch_taken = 1'b0; imem_valid = 1'b1; imem_rdata = 8'h22;
        tick;
        check("seq_wrap_pc", pc, 16'h00);
        check("seq_wrap_id_pc", id_pc, 16'hFF);

        // 8'hFF instruction at pc 00
        imem_rdata = 8'hFF;
        tick;
        check("ff_instr", id_instr, 16'hFF);
`ifdef HALT_DETECT_EN
        imem_valid = 1'b0;
        check("halt_flag", halted, 16'h1);
        check("halt_req", imem_req, 16'h0);
        imem_valid = 1'b1; imem_rdata = 8'h12;
        tick;
        check("halt_hold", halted, 16'h1);
        check("halt_pc", pc, 16'h01);
        check("halt_req2", imem_req, 16'h0);
        check("halt_instr", id_instr, 16'hFF);
        branch_taken = 1'b1; branch_offset = 8'h01;
        tick;
        branch_taken = 1'b0;
        check("unhalt_flag", halted, 16'h0);
        check("unhalt_req", imem_req, 16'h1);
`else
        check("ff_halted", halted, 16'h0);
        check("ff_req", imem_req, 16'h1);
        check("ff_valid", id_valid, 16'h1);
        imem_rdata = 8'h12;
        tick;
        check("after_ff_instr", id_instr, 16'h12);
        check("after_ff_id_pc", id_pc, 16'h01);
`endif
        check("pc_02", pc, 16'h02);

        // Branch while stalled in HOLD drops the skid entry
        imem_valid = 1'b1; imem_rdata = 8'h30;
        tick;
        check("f30_id_pc", id_pc, 16'h02);
        imem_rdata = 8'h44; stall = 1'b1;
        tick;
        check("hold_req", imem_req, 16'h0);
        check("hold_pc", pc, 16'h04);
        branch_taken = 1'b1; branch_offset = 8'h05;
        tick;
        check("hbr_pc", pc, 16'h08);
        check("hbr_req", imem_req, 16'h1);
        check("hbr_addr", imem_addr, 16'h08);
        check("hbr_valid", id_valid, 16'h0);
        branch_taken = 1'b0; imem_valid = 1'b0;
        tick;
        check("hbr_st_valid", id_valid, 16'h0);
        check("hbr_st_pc", pc, 16'h08);
        stall = 1'b0;
        tick;
        check("flushed_valid", id_valid, 16'h0);
        check("flushed_instr", id_instr, 16'h30);

        // Reset in the middle of a stall
        imem_valid = 1'b1; imem_rdata = 8'h55; stall = 1'b1;
        tick;
        check("pre_rst_req", imem_req, 16'h0);
        check("pre_rst_pc", pc, 16'h09);
        rst = 1'b1;
        tick;
        check("mid_rst_pc", pc, 16'h00);
        check("mid_rst_valid", id_valid, 16'h0);
        check("mid_rst_req", imem_req, 16'h1);
        check("mid_rst_instr", id_instr, 16'h00);
        rst = 1'b0; imem_valid = 1'b0; stall = 1'b0;
        tick;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
